ro_pair_arbiter: RTL and testbench

// - Downstream consumer of two ring-oscillator edge counters (free-running CW-bit counts, one per oscillator bank).
// - Steps a pair-select index through NBITS oscillator pairs.
// - For each pair, measures both counts' increments over a fixed clock window and emits 1 response bit:
//   1 if A is faster than B, else 0.
// - Assembles an NBITS-bit PUF/entropy response for the crypto datapath, with start/busy/done handshake.

---
 rtl/ro_pair_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_ro_pair_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ro_pair_arbiter.sv
// ro_pair_arbiter
// Walks NBITS ring-oscillator pairs. For each pair it lets the muxes settle,
// snapshots both free-running edge counters, waits a fixed window, and
// snapshots them again. Response bit i is 1 when bank A advanced further than
// bank B on pair i. All counter arithmetic is modulo 2^CW.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   start             request a full response (accepted only when idle)
//   abort             synchronous abort back to idle, no done pulse
//   count_a, count_b  running edge counts of oscillator banks A and B
//   sel               current pair index, drives the oscillator muxes
//   busy              high whenever the arbiter is not idle
//   done              one-cycle pulse, response valid
//   response          collected response bits, bit i = pair i
//   tie_count         pairs whose two deltas were equal in the last run
module ro_pair_arbiter #(
    parameter int unsigned CW     = 8,
    parameter int unsigned NBITS  = 16,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned WINDOW = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [CW-1:0]              count_a,
    input  logic [CW-1:0]              count_b,
    output logic [$clog2(NBITS)-1:0]   sel,
    output logic                       busy,
    output logic                       done,
    output logic [NBITS-1:0]           response,
    output logic [$clog2(NBITS+1)-1:0] tie_count
);

    localparam int unsigned SW   = $clog2(NBITS);
    localparam int unsigned TCW  = $clog2(NBITS + 1);
    localparam int unsigned TMAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SNAP,
        S_MEASURE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [SW-1:0]     r_sel;
    logic              r_busy;
    logic              r_done;
    logic [NBITS-1:0]  r_response;
    logic [TCW-1:0]    r_tie_count;
    logic [TW-1:0]     r_timer;
    logic [CW-1:0]     r_base_a;
    logic [CW-1:0]     r_base_b;
    logic [CW-1:0]     r_end_a;
    logic [CW-1:0]     r_end_b;

    logic [CW-1:0]     w_delta_a;
    logic [CW-1:0]     w_delta_b;
    logic              w_a_wins;
    logic              w_tie;
    logic              w_last_pair;
    logic              w_timer_zero;

    // Modulo deltas absorb a single counter wrap inside the window
    always_comb begin
        w_delta_a    = r_end_a - r_base_a;
        w_delta_b    = r_end_b - r_base_b;
        w_a_wins     = (w_delta_a > w_delta_b);
        w_tie        = (w_delta_a == w_delta_b);
        w_last_pair  = (r_sel == SW'(NBITS - 1));
        w_timer_zero = (r_timer == '0);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort wins over start and over every busy state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start && !abort) w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)             w_state_next = S_IDLE;
                else if (w_timer_zero) w_state_next = S_SNAP;
            end
            S_SNAP: begin
                if (abort) w_state_next = S_IDLE;
                else       w_state_next = S_MEASURE;
            end
            S_MEASURE: begin
                if (abort)             w_state_next = S_IDLE;
                else if (w_timer_zero) w_state_next = S_COMPARE;
            end
            S_COMPARE: begin
                if (abort)            w_state_next = S_IDLE;
                else if (w_last_pair) w_state_next = S_DONE;
                else                  w_state_next = S_SETTLE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: timer, snapshots, pair index and response accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_response  <= '0;
            r_tie_count <= '0;
            r_timer     <= '0;
            r_base_a    <= '0;
            r_base_b    <= '0;
            r_end_a     <= '0;
            r_end_b     <= '0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (w_state_next == S_DONE);
            if (abort && (r_state != S_IDLE)) begin
                // Partial response/tie_count are left as-is; they are not valid
                r_sel   <= '0;
                r_timer <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_sel       <= '0;
                            r_response  <= '0;
                            r_tie_count <= '0;
                            r_timer     <= TW'(SETTLE - 1);
                        end
                    end
                    S_SETTLE: begin
                        if (!w_timer_zero) r_timer <= r_timer - TW'(1);
                    end
                    S_SNAP: begin
                        r_base_a <= count_a;
                        r_base_b <= count_b;
                        r_timer  <= TW'(WINDOW - 1);
                    end
                    S_MEASURE: begin
                        if (w_timer_zero) begin
                            r_end_a <= count_a;
                            r_end_b <= count_b;
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    S_COMPARE: begin
                        r_response[r_sel] <= w_a_wins;
                        if (w_tie) r_tie_count <= r_tie_count + TCW'(1);
                        if (!w_last_pair) begin
                            r_sel   <= r_sel + SW'(1);
                            r_timer <= TW'(SETTLE - 1);
                        end
                    end
                    S_DONE: begin
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign sel       = r_sel;
    assign busy      = r_busy;
    assign done      = r_done;
    assign response  = r_response;
    assign tie_count = r_tie_count;

endmodule

// File: tb/tb_ro_pair_arbiter.sv
// Testbench for ro_pair_arbiter: table-driven full runs, randomized runs
// against a window-timing reference model, and abort/reset/start corner cases.
module tb_ro_pair_arbiter;

    localparam int unsigned CW     = 8;
    localparam int unsigned NBITS  = 16;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned WINDOW = 256;
    localparam int          P      = SETTLE + WINDOW + 2;
    localparam int          TOT    = NBITS * P;
    localparam int          MASK   = (1 << CW) - 1;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic                       abort;
    logic [CW-1:0]              count_a;
    logic [CW-1:0]              count_b;
    logic [$clog2(NBITS)-1:0]   sel;
    logic                       busy;
    logic                       done;
    logic [NBITS-1:0]           response;
    logic [$clog2(NBITS+1)-1:0] tie_count;

    ro_pair_arbiter #(
        .CW(CW), .NBITS(NBITS), .SETTLE(SETTLE), .WINDOW(WINDOW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .count_a(count_a), .count_b(count_b),
        .sel(sel), .busy(busy), .done(done),
        .response(response), .tie_count(tie_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Counter value present at each edge of the current run (unbounded ints)
    int ha [0:TOT+8];
    int hb [0:TOT+8];
    // Increment period per pair; 0 = random, at most one edge per 2 clocks
    int ra [NBITS];
    int rb [NBITS];

    typedef struct {
        int              mode;
        int              a0;
        int              b0;
        int              restart_at;
        logic [NBITS-1:0] exp_resp;
        int              exp_tie;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // 0: A every 2, B every 4; 1: both every 4; 2: alternate per pair; 3: random
    task automatic set_mode(input int mode);
        for (int p = 0; p < int'(NBITS); p++) begin
            case (mode)
                0: begin ra[p] = 2; rb[p] = 4; end
                1: begin ra[p] = 4; rb[p] = 4; end
                2: begin ra[p] = (p % 2 == 0) ? 2 : 4; rb[p] = (p % 2 == 0) ? 4 : 2; end
                default: begin
                    ra[p] = int'($urandom_range(0, 5));
                    rb[p] = int'($urandom_range(0, 5));
                    if (ra[p] == 1) ra[p] = 0;
                    if (rb[p] == 1) rb[p] = 0;
                end
            endcase
        end
    endtask

    function automatic int step(input int period, input int k);
        if (period > 0) return (k % period == 0) ? 1 : 0;
        return ((k % 2 == 0) && ($urandom_range(0, 1) == 1)) ? 1 : 0;
    endfunction

    // Reference: bit i compares counter advance between the edge after
    // SNAP (i*P+SETTLE+1) and WINDOW edges later, modulo 2^CW
    task automatic model(output logic [NBITS-1:0] m_resp, output int m_tie);
        m_resp = '0;
        m_tie  = 0;
        for (int i = 0; i < int'(NBITS); i++) begin
            int eb = i * P + int'(SETTLE) + 1;
            int ee = eb + int'(WINDOW);
            int da = (ha[ee] - ha[eb]) & MASK;
            int db = (hb[ee] - hb[eb]) & MASK;
            m_resp[i] = (da > db);
            if (da == db) m_tie++;
        end
    endtask

    // One run from a start pulse; optional mid-run start, abort or reset
    task automatic run(input int a0, input int b0, input int restart_at,
                       input int abort_at, input int rst_at, input string tag);
        int first_bad = -1;
        int last = (abort_at >= 0) ? abort_at + 4 : TOT + 2;
        logic exp_busy, exp_done;
        int exp_sel;
        @(negedge clk);
        start = 1'b1;
        ha[0] = a0; hb[0] = b0;
        count_a = CW'(a0); count_b = CW'(b0);
        for (int e = 0; e <= last; e++) begin
            int k;
            int p;
            @(posedge clk);
            #1;
            exp_busy = (e <= TOT);
            exp_done = (e == TOT);
            exp_sel  = (e < TOT) ? e / P : int'(NBITS) - 1;
            if (abort_at >= 0 && e >= abort_at) begin
                exp_busy = 1'b0; exp_done = 1'b0; exp_sel = 0;
            end
            if (first_bad < 0 && (busy !== exp_busy || done !== exp_done || int'(sel) != exp_sel))
                first_bad = e;
            @(negedge clk);
            k = e + 1;
            start = (k == restart_at);
            abort = (k == abort_at);
            p = k / P;
            if (p >= int'(NBITS)) p = int'(NBITS) - 1;
            ha[k] = ha[k-1] + step(ra[p], k);
            hb[k] = hb[k-1] + step(rb[p], k);
            count_a = CW'(ha[k]);
            count_b = CW'(hb[k]);
            if (k == rst_at) begin
                check({tag, "_pre_rst_busy"}, 32'(busy), 32'd1);
                rst = 1'b1;
                #1;
                check({tag, "_async_rst"}, 32'({sel, busy, done, response, tie_count}), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                check({tag, "_timeline"}, first_bad, -1);
                return;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        check({tag, "_timeline"}, first_bad, -1);
    endtask

    task automatic check_model(input string tag);
        logic [NBITS-1:0] m_resp;
        int m_tie;
        model(m_resp, m_tie);
        check({tag, "_resp_model"}, 32'(response), 32'(m_resp));
        check({tag, "_tie_model"}, 32'(tie_count), m_tie);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        count_a = '0; count_b = '0;

        tbl[0] = '{mode: 0, a0: 0,   b0: 0,   restart_at: 2000, exp_resp: 16'hFFFF, exp_tie: 0};
        tbl[1] = '{mode: 1, a0: 0,   b0: 0,   restart_at: -1,   exp_resp: 16'h0000, exp_tie: 16};
        tbl[2] = '{mode: 2, a0: 17,  b0: 3,   restart_at: -1,   exp_resp: 16'h5555, exp_tie: 0};
        // A reaches 250 at the first snapshot and wraps to 122 by its end
        tbl[3] = '{mode: 0, a0: 248, b0: 200, restart_at: -1,   exp_resp: 16'hFFFF, exp_tie: 0};

        #12;
        check("reset_outputs", 32'({sel, busy, done, response, tie_count}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            set_mode(tbl[i].mode);
            run(tbl[i].a0, tbl[i].b0, tbl[i].restart_at, -1, -1, tag);
            check({tag, "_resp"}, 32'(response), 32'(tbl[i].exp_resp));
            check({tag, "_tie"}, 32'(tie_count), tbl[i].exp_tie);
            check_model(tag);
        end

        // start and abort together while idle: abort wins
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        check("idle_abort_wins_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        check("idle_abort_wins_busy2", 32'(busy), 32'd0);

        // abort at edge 1000, then a full randomized run
        set_mode(0);
        run(0, 0, -1, 1000, -1, "abort");
        set_mode(3);
        run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1, -1, -1, "post_abort");
        check_model("post_abort");

        // reset in the middle of pair 1's window, then a normal run
        set_mode(0);
        run(0, 0, -1, -1, 400, "rst_mid");
        set_mode(2);
        run(5, 9, -1, -1, -1, "post_rst");
        check("post_rst_resp", 32'(response), 32'(16'h5555));
        check_model("post_rst");

        for (int r = 0; r < 3; r++) begin
            string tag;
            tag = $sformatf("rand%0d", r);
            set_mode(3);
            run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(1, TOT - 1)), -1, -1, tag);
            check_model(tag);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
